// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits on a
// shared segment bus. A load strobe latches a packed hex value, per-digit decimal
// points and per-digit blink enables. The driver then scans one digit per slot of
// PRESCALE clocks and decodes that digit's nibble to active-low segments.
//
// Ports:
//   clk, reset_n  - clock (rising edge), asynchronous active-low reset
//   en            - display enable; 0 darkens the pins while counters keep running
//   load          - 1-cycle strobe capturing value / dp_in / blink_mask
//   value         - packed hex digits, digit 0 in value[3:0]
//   dp_in         - decimal point request per digit (1 = lit)
//   blink_mask    - per-digit blink enable
//   blank_lz      - live leading-zero suppression request
//   seg_n         - segments {A..G}, active-low, seg_n[6] = A
//   dp_n          - decimal point, active-low
//   an_n          - one-hot active-low anode select
//   frame_tick    - 1-cycle pulse when the scan wraps back to digit 0
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned BLINK_DIV  = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned FR_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_DIV - 1);

  // Counter and shadow state
  logic [PS_W-1:0]       presc_q,  presc_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [FR_W-1:0]       frame_q,  frame_d;
  logic                  blink_q,  blink_d;
  logic [VAL_W-1:0]      value_q,  value_d;
  logic [NUM_DIGITS-1:0] dp_q,     dp_d;
  logic [NUM_DIGITS-1:0] mask_q,   mask_d;
  logic                  slot_end, wrap;

  // Next values of the output registers
  logic [6:0]            seg_d;
  logic                  dp_n_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Output-path helpers
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_above;
  logic [3:0]            nib;
  logic                  dp_sel, mask_sel, lz_sel, blanked;

  // Hex nibble to active-low {A..G}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      blink_q    <= 1'b0;
      value_q    <= '0;
      dp_q       <= '0;
      mask_q     <= '0;
      seg_n      <= '1;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      mask_q     <= mask_d;
      seg_n      <= seg_d;
      dp_n       <= dp_n_d;
      an_n       <= an_d;
      frame_tick <= wrap;
    end
  end

  // Next state: prescaler, digit index, frame/blink counters, shadow capture
  always_comb begin
    slot_end = (presc_q == PS_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    presc_d  = slot_end ? '0 : presc_q + PS_W'(1);
    idx_d    = idx_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    value_d  = value_q;
    dp_d     = dp_q;
    mask_d   = mask_q;

    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      if (frame_q == FR_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FR_W'(1);
      end
    end
    if (load) begin
      value_d = value;
      dp_d    = dp_in;
      mask_d  = blink_mask;
    end
  end

  // Output decode. Looks at the slot about to start (presc_d/idx_d) so the
  // registered pins line up with the counters; data comes from the current
  // shadow, so a load only shows from the cycle after its capture edge.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    nib        = 4'h0;
    dp_sel     = 1'b0;
    mask_sel   = 1'b0;
    lz_sel     = 1'b0;
    seg_d      = '1;
    dp_n_d     = 1'b1;
    an_d       = '1;

    // A digit is a leading zero if it and every digit above it are zero;
    // digit 0 is never suppressed so a zero value still shows "0".
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (value_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        lz_blank[i] = zero_above;
      end
    end

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib      = value_q[4*i +: 4];
        dp_sel   = dp_q[i];
        mask_sel = mask_q[i];
        lz_sel   = lz_blank[i];
      end
    end

    blanked = (blank_lz && lz_sel) || (mask_sel && blink_q);

    // First cycle of each slot stays fully dark to avoid ghosting
    if (en && (presc_d != '0)) begin
      an_d = ~(NUM_DIGITS'(1) << idx_d);
      if (!blanked) begin
        seg_d  = hex_to_seg(nib);
        dp_n_d = ~dp_sel;
      end
    end
  end

endmodule
